// File: rtl/sa_acc_pkg.sv
// Shared constants, FSM state type and output saturation helper for the
// partial-sum accumulator.
package sa_acc_pkg;

    localparam int unsigned COLS  = 16;
    localparam int unsigned DEPTH = 784;
    localparam int unsigned ACC_W = 16;
    localparam int unsigned PIX_W = 10;

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    // Input is already non-negative (post-ReLU), so only the upper bound matters.
    function automatic logic [7:0] sat_u8(input logic [ACC_W-1:0] val);
        return (val > ACC_W'(255)) ? 8'hff : val[7:0];
    endfunction

endpackage

// File: rtl/sa_acc_col.sv
// One accumulator column: pixel/pass counters, partial-sum store, read-modify-write
// datapath and the registered activation output.
module sa_acc_col
    import sa_acc_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear_i,
    input  logic             run_i,
    input  logic [3:0]       last_pass_i,
    input  logic [PIX_W-1:0] npix_i,
    input  logic [2:0]       shift_i,
    input  logic [7:0]       data_i,
    input  logic             valid_i,
    output logic [7:0]       out_data_o,
    output logic             out_valid_o,
    output logic [PIX_W-1:0] out_addr_o,
    output logic             done_next_o
);

    logic [PIX_W-1:0] pix_cnt_q, pix_cnt_d;
    logic [3:0]       pass_cnt_q, pass_cnt_d;
    logic             done_q, done_d;
    logic [ACC_W-1:0] mem_q [DEPTH];

    logic             accept, last_pix, last_pass, emit;
    logic [ACC_W-1:0] data_ext, sum, relu, shifted;

    // Asynchronous read sees the previous cycle's write, so npix=1 back-to-back
    // accepts accumulate correctly without a separate bypass path.
    always_comb begin
        accept    = run_i & valid_i & ~done_q;
        last_pix  = (pix_cnt_q == npix_i - PIX_W'(1));
        last_pass = (pass_cnt_q == last_pass_i);
        emit      = accept & last_pass;
        data_ext  = {{(ACC_W-8){data_i[7]}}, data_i};
        sum       = (pass_cnt_q == 4'd0) ? data_ext : mem_q[pix_cnt_q] + data_ext;
        relu      = sum[ACC_W-1] ? '0 : sum;
        shifted   = relu >> shift_i;
    end

    always_comb begin
        pix_cnt_d  = pix_cnt_q;
        pass_cnt_d = pass_cnt_q;
        done_d     = done_q;
        if (clear_i) begin
            pix_cnt_d  = '0;
            pass_cnt_d = '0;
            done_d     = 1'b0;
        end else if (accept) begin
            if (last_pix) begin
                pix_cnt_d = '0;
                if (last_pass) begin
                    done_d = 1'b1;
                end else begin
                    pass_cnt_d = pass_cnt_q + 4'd1;
                end
            end else begin
                pix_cnt_d = pix_cnt_q + PIX_W'(1);
            end
        end
    end

    assign done_next_o = done_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pix_cnt_q   <= '0;
            pass_cnt_q  <= '0;
            done_q      <= 1'b0;
            out_valid_o <= 1'b0;
            out_data_o  <= '0;
            out_addr_o  <= '0;
        end else begin
            pix_cnt_q   <= pix_cnt_d;
            pass_cnt_q  <= pass_cnt_d;
            done_q      <= done_d;
            out_valid_o <= emit;
            if (emit) begin
                out_data_o <= sat_u8(shifted);
                out_addr_o <= pix_cnt_q;
            end
        end
    end

    // Storage is deliberately unreset: pass 0 never reads it.
    always_ff @(posedge clk) begin
        if (accept) begin
            mem_q[pix_cnt_q] <= sum;
        end
    end

endmodule

// File: rtl/sa_accumulator.sv
// Partial-sum accumulator: layer-level FSM and config latch around COLS
// independent accumulator columns.
module sa_accumulator
    import sa_acc_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       num_pass_i,
    input  logic [4:0]       ofmap_size_i,
    input  logic [2:0]       shift_i,
    input  logic [7:0]       accu_data_i [COLS],
    input  logic [COLS-1:0]  accu_valid_i,
    output logic [7:0]       out_data_o [COLS],
    output logic [COLS-1:0]  out_valid_o,
    output logic [PIX_W-1:0] out_addr_o [COLS],
    output logic             busy_o,
    output logic             done_o
);

    state_e           state_q, state_d;
    logic [PIX_W-1:0] npix_q;
    logic [3:0]       last_pass_q;
    logic [2:0]       shift_q;
    logic             start_acc, run;
    logic [COLS-1:0]  done_next;

    assign start_acc = (state_q == StIdle) & start;
    assign run       = (state_q == StRun);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state uses the columns' next done flags so done_o lines up with the
    // last column's final output pulse.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start) state_d = StRun;
            StRun:   if (&done_next) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        busy_o = (state_q == StRun);
        done_o = (state_q == StDone);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            npix_q      <= '0;
            last_pass_q <= '0;
            shift_q     <= '0;
        end else if (start_acc) begin
            npix_q      <= PIX_W'(ofmap_size_i) * PIX_W'(ofmap_size_i);
            last_pass_q <= num_pass_i;
            shift_q     <= shift_i;
        end
    end

    for (genvar c = 0; c < COLS; c++) begin : g_col
        sa_acc_col u_col (
            .clk         (clk),
            .rst_n       (rst_n),
            .clear_i     (start_acc),
            .run_i       (run),
            .last_pass_i (last_pass_q),
            .npix_i      (npix_q),
            .shift_i     (shift_q),
            .data_i      (accu_data_i[c]),
            .valid_i     (accu_valid_i[c]),
            .out_data_o  (out_data_o[c]),
            .out_valid_o (out_valid_o[c]),
            .out_addr_o  (out_addr_o[c]),
            .done_next_o (done_next[c])
        );
    end

endmodule

// File: tb/tb_sa_accumulator.sv
// Self-checking bench for sa_accumulator: random per-column streams scored
// against an arithmetic reference model of the multi-pass accumulation.
module tb_sa_accumulator;
    import sa_acc_pkg::*;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [3:0]       num_pass_i = '0;
    logic [4:0]       ofmap_size_i = 5'd1;
    logic [2:0]       shift_i = '0;
    logic [7:0]       accu_data_i [COLS];
    logic [COLS-1:0]  accu_valid_i = '0;
    logic [7:0]       out_data_o [COLS];
    logic [COLS-1:0]  out_valid_o;
    logic [PIX_W-1:0] out_addr_o [COLS];
    logic             busy_o, done_o;

    sa_accumulator dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .num_pass_i   (num_pass_i),
        .ofmap_size_i (ofmap_size_i),
        .shift_i      (shift_i),
        .accu_data_i  (accu_data_i),
        .accu_valid_i (accu_valid_i),
        .out_data_o   (out_data_o),
        .out_valid_o  (out_valid_o),
        .out_addr_o   (out_addr_o),
        .busy_o       (busy_o),
        .done_o       (done_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0] stim [COLS][$];
    int obs_addr [COLS][$];
    int obs_data [COLS][$];
    int last_out_cyc [COLS];
    int done_cnt = 0;
    int done_cyc = -1;

    always @(negedge clk) begin
        for (int c = 0; c < COLS; c++) begin
            if (out_valid_o[c]) begin
                obs_addr[c].push_back(int'(out_addr_o[c]));
                obs_data[c].push_back(int'(out_data_o[c]));
                last_out_cyc[c] = cyc;
            end
        end
        if (done_o) begin
            done_cnt++;
            done_cyc = cyc;
        end
    end

    task automatic clear_obs();
        for (int c = 0; c < COLS; c++) begin
            obs_addr[c].delete();
            obs_data[c].delete();
            last_out_cyc[c] = -1;
        end
        done_cnt = 0;
        done_cyc = -1;
    endtask

    task automatic fill_random(int total);
        for (int c = 0; c < COLS; c++) begin
            stim[c].delete();
            for (int i = 0; i < total; i++) stim[c].push_back(8'($urandom));
        end
    endtask

    // Drives one layer from stim[], then scores every column against the model.
    task automatic run_and_score(string name, int size, int npass, int sh,
                                 bit skew, bit gaps, bit restart_mid);
        int npix, total, t, latest, ev;
        int idx [COLS];
        bit all_in;
        shortint acc;
        npix  = size * size;
        total = npix * (npass + 1);
        clear_obs();
        start = 1'b1;
        ofmap_size_i = 5'(size);
        num_pass_i = 4'(npass);
        shift_i = 3'(sh);
        @(posedge clk); #1;
        start = 1'b0;
        checks++;
        if (busy_o !== 1'b1) begin
            failures++;
            $display("FAIL %s busy_after_start: got %b want 1", name, busy_o);
        end
        for (int c = 0; c < COLS; c++) idx[c] = 0;
        t = 0;
        all_in = 1'b0;
        while (!all_in && t < 4000) begin
            for (int c = 0; c < COLS; c++) begin
                if (idx[c] < total && (!skew || t >= c) && (!gaps || $urandom_range(3) != 0)) begin
                    accu_valid_i[c] = 1'b1;
                    accu_data_i[c] = stim[c][idx[c]];
                    idx[c]++;
                end else begin
                    accu_valid_i[c] = 1'b0;
                    accu_data_i[c] = 8'($urandom);
                end
            end
            if (restart_mid && t == 1) begin
                start = 1'b1;
                ofmap_size_i = 5'(size + 1);
                num_pass_i = 4'(npass + 1);
                shift_i = 3'(sh + 1);
            end
            @(posedge clk); #1;
            start = 1'b0;
            t++;
            all_in = 1'b1;
            for (int c = 0; c < COLS; c++) if (idx[c] < total) all_in = 1'b0;
        end
        accu_valid_i = '0;
        t = 0;
        while (done_cnt == 0 && t < 20) begin
            @(posedge clk); #1;
            t++;
        end
        repeat (3) begin
            @(posedge clk); #1;
        end
        latest = -1;
        for (int c = 0; c < COLS; c++) if (last_out_cyc[c] > latest) latest = last_out_cyc[c];
        checks++;
        if (done_cnt != 1) begin
            failures++;
            $display("FAIL %s done_count: got %0d want 1", name, done_cnt);
        end
        checks++;
        if (done_cyc != latest) begin
            failures++;
            $display("FAIL %s done_timing: got cycle %0d want %0d", name, done_cyc, latest);
        end
        checks++;
        if (busy_o !== 1'b0) begin
            failures++;
            $display("FAIL %s busy_after_done: got %b want 0", name, busy_o);
        end
        for (int c = 0; c < COLS; c++) begin
            checks++;
            if (obs_data[c].size() != npix) begin
                failures++;
                $display("FAIL %s col%0d out_count: got %0d want %0d",
                         name, c, obs_data[c].size(), npix);
            end
            for (int p = 0; p < npix && p < obs_data[c].size(); p++) begin
                acc = 0;
                for (int k = 0; k <= npass; k++) acc += shortint'(byte'(stim[c][k * npix + p]));
                ev = (acc < 0) ? 0 : (int'(acc) >>> sh);
                if (ev > 255) ev = 255;
                checks++;
                if (obs_addr[c][p] != p || obs_data[c][p] != ev) begin
                    failures++;
                    $display("FAIL %s col%0d pix%0d: got addr %0d data %0d want addr %0d data %0d",
                             name, c, p, obs_addr[c][p], obs_data[c][p], p, ev);
                end
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (busy_o !== 1'b0 || done_o !== 1'b0 || out_valid_o !== '0) begin
            failures++;
            $display("FAIL reset_ctrl: got busy %b done %b valid %h want 0 0 0",
                     busy_o, done_o, out_valid_o);
        end
        for (int c = 0; c < COLS; c++) begin
            checks++;
            if (out_data_o[c] !== 8'd0 || out_addr_o[c] !== 10'd0) begin
                failures++;
                $display("FAIL reset_col%0d: got data %0d addr %0d want 0 0",
                         c, out_data_o[c], out_addr_o[c]);
            end
        end
    endtask

    task automatic test_single_pass();
        int exp_c0 [4] = '{5, 0, 100, 127};
        fill_random(4);
        stim[0][0] = 8'd5;
        stim[0][1] = 8'hfd;
        stim[0][2] = 8'd100;
        stim[0][3] = 8'd127;
        run_and_score("single_pass", 2, 0, 0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4 && i < obs_data[0].size(); i++) begin
            checks++;
            if (obs_data[0][i] != exp_c0[i]) begin
                failures++;
                $display("FAIL single_pass_c0[%0d]: got %0d want %0d", i, obs_data[0][i], exp_c0[i]);
            end
        end
    endtask

    task automatic test_multi_pass_sat();
        int want;
        for (int sh = 0; sh < 2; sh++) begin
            for (int c = 0; c < COLS; c++) begin
                stim[c].delete();
                for (int i = 0; i < 12; i++) stim[c].push_back(8'd100);
            end
            run_and_score("multi_pass_sat", 2, 2, sh, 1'b0, 1'b0, 1'b0);
            want = (sh == 0) ? 255 : 150;
            for (int c = 0; c < COLS; c++) begin
                checks++;
                if (obs_data[c].size() == 0 || obs_data[c][obs_data[c].size() - 1] != want) begin
                    failures++;
                    $display("FAIL multi_pass_sat sh%0d col%0d: got %0d want %0d", sh, c,
                             (obs_data[c].size() == 0) ? -1 : obs_data[c][0], want);
                end
            end
        end
    endtask

    task automatic test_skewed();
        fill_random(18);
        run_and_score("skewed", 3, 1, 2, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back();
        for (int c = 0; c < COLS; c++) begin
            stim[c].delete();
            for (int i = 1; i <= 4; i++) stim[c].push_back(8'(10 * i + c));
        end
        run_and_score("back_to_back", 1, 3, 0, 1'b0, 1'b0, 1'b0);
        for (int c = 0; c < COLS; c++) begin
            checks++;
            if (obs_data[c].size() != 1 || obs_data[c][0] != 100 + 4 * c) begin
                failures++;
                $display("FAIL back_to_back col%0d: got %0d outputs first %0d want 1 output %0d",
                         c, obs_data[c].size(), (obs_data[c].size() == 0) ? -1 : obs_data[c][0],
                         100 + 4 * c);
            end
        end
    endtask

    task automatic test_reset_mid_run();
        fill_random(27);
        clear_obs();
        start = 1'b1;
        ofmap_size_i = 5'd3;
        num_pass_i = 4'd2;
        shift_i = 3'd0;
        @(posedge clk); #1;
        start = 1'b0;
        for (int t = 0; t < 12; t++) begin
            for (int c = 0; c < COLS; c++) accu_data_i[c] = stim[c][t];
            accu_valid_i = '1;
            @(posedge clk); #1;
        end
        accu_valid_i = '0;
        rst_n = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
        end
        rst_n = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
        end
        checks++;
        if (busy_o !== 1'b0 || done_cnt != 0) begin
            failures++;
            $display("FAIL reset_mid_run abort: got busy %b done_pulses %0d want 0 0",
                     busy_o, done_cnt);
        end
        fill_random(9);
        run_and_score("after_reset", 3, 0, 0, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic test_idle_and_start_ignored();
        int n_out;
        clear_obs();
        for (int t = 0; t < 5; t++) begin
            for (int c = 0; c < COLS; c++) accu_data_i[c] = 8'($urandom);
            accu_valid_i = COLS'($urandom);
            @(posedge clk); #1;
        end
        accu_valid_i = '0;
        repeat (2) begin
            @(posedge clk); #1;
        end
        n_out = 0;
        for (int c = 0; c < COLS; c++) n_out += obs_data[c].size();
        checks++;
        if (n_out != 0 || done_cnt != 0 || busy_o !== 1'b0) begin
            failures++;
            $display("FAIL idle_valid: got outputs %0d done %0d busy %b want 0 0 0",
                     n_out, done_cnt, busy_o);
        end
        fill_random(8);
        run_and_score("start_in_run", 2, 1, 1, 1'b1, 1'b1, 1'b1);
    endtask

    task automatic test_random();
        int size, npass, sh;
        for (int it = 0; it < 4; it++) begin
            size = $urandom_range(6, 1);
            npass = $urandom_range(3, 0);
            sh = $urandom_range(7, 0);
            fill_random(size * size * (npass + 1));
            run_and_score("random", size, npass, sh, 1'($urandom), 1'b1, 1'b0);
        end
    endtask

    initial begin
        for (int c = 0; c < COLS; c++) accu_data_i[c] = '0;
        test_reset();
        test_single_pass();
        test_multi_pass_sat();
        test_skewed();
        test_back_to_back();
        test_reset_mid_run();
        test_idle_and_start_ignored();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
